// File: rtl/cam_lookup_arbiter_pkg.sv
// cam_lookup_arbiter_pkg: one-hot FSM encoding and width helper shared by the arbiter files
package cam_lookup_arbiter_pkg;
  typedef enum logic [3:0] {
    ARB     = 4'b0001,
    DRAIN   = 4'b0010,
    WRITE   = 4'b0100,
    WR_WAIT = 4'b1000
  } state_t;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cam_lookup_arbiter_tag_fifo.sv
// arb_tag_fifo: in-order queue of requester tags for lookups still in the CAM pipeline
module arb_tag_fifo
  import cam_lookup_arbiter_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/cam_lookup_arbiter.sv
// cam_lookup_arbiter: round-robin sharing of one CAM compare port, serialised against table writes
module cam_lookup_arbiter
  import cam_lookup_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int REQ_IDX_WIDTH = clog2(NUM_REQ),
  parameter int KEY_WIDTH     = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int MAX_OUT       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*KEY_WIDTH-1:0] req_key,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           rsp_vld,
  output logic                         rsp_hit,
  output logic [ADDR_WIDTH-1:0]        rsp_addr,
  input  logic                         wr_req,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [KEY_WIDTH-1:0]         wr_data,
  output logic                         wr_ack,
  output logic                         cam_cmp_req,
  output logic [KEY_WIDTH-1:0]         cam_cmp_din,
  output logic                         cam_we,
  output logic [ADDR_WIDTH-1:0]        cam_wr_addr,
  output logic [KEY_WIDTH-1:0]         cam_din,
  input  logic                         cam_busy,
  input  logic                         cam_rsp_vld,
  input  logic                         cam_match,
  input  logic [ADDR_WIDTH-1:0]        cam_match_addr,
  output logic                         rsp_orphan
);
  localparam int OW = clog2(MAX_OUT) + 1;
  state_t state;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr, win, idx, tag;
  logic [OW-1:0] outstanding;
  logic [NUM_REQ-1:0] elig;
  logic [KEY_WIDTH-1:0] keys [NUM_REQ];
  logic lookup_first, go_drain, grant, pop, empty, full;
  for (genvar i = 0; i < NUM_REQ; i++) assign keys[i] = req_key[i*KEY_WIDTH +: KEY_WIDTH];
  // a requester whose ack is showing is still holding req_vld for this one cycle
  assign elig     = req_vld & ~req_ack;
  // right after a write, one pending lookup goes ahead of the next write
  assign go_drain = state == ARB && wr_req && !(lookup_first && |elig);
  assign grant    = state == ARB && !go_drain && !cam_busy && !full &&
                    outstanding < OW'(MAX_OUT) && |elig;
  assign pop      = cam_rsp_vld && !empty;
  assign wr_ack   = state == WR_WAIT && !cam_busy;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = REQ_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      win = elig[idx] ? idx : win;
    end
  end
  arb_tag_fifo #(.W(REQ_IDX_WIDTH), .DEPTH(MAX_OUT)) u_tags (
    .clk, .reset, .push(grant), .din(win), .pop, .dout(tag), .empty, .full
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= ARB;
      rr_ptr       <= '0;
      outstanding  <= '0;
      lookup_first <= 1'b0;
      req_ack      <= '0;
      cam_cmp_req  <= 1'b0;
      cam_cmp_din  <= '0;
      rsp_vld      <= '0;
      rsp_hit      <= 1'b0;
      rsp_addr     <= '0;
      rsp_orphan   <= 1'b0;
      cam_we       <= 1'b0;
      cam_wr_addr  <= '0;
      cam_din      <= '0;
    end else begin
      req_ack     <= grant ? NUM_REQ'(1) << win : '0;
      cam_cmp_req <= grant;
      if (grant) begin
        cam_cmp_din <= keys[win];
        rr_ptr      <= win == REQ_IDX_WIDTH'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      outstanding <= outstanding + OW'(grant) - OW'(pop);
      rsp_vld     <= pop ? NUM_REQ'(1) << tag : '0;
      rsp_hit     <= pop && cam_match;
      rsp_addr    <= pop ? cam_match_addr : '0;
      rsp_orphan  <= rsp_orphan || (cam_rsp_vld && empty);
      cam_we      <= 1'b0;
      if (grant || go_drain) lookup_first <= 1'b0;
      case (state)
        ARB:     if (go_drain) state <= DRAIN;
        DRAIN:   if (outstanding == '0 && !cam_busy) begin
          state       <= WRITE;
          cam_we      <= 1'b1;
          cam_wr_addr <= wr_addr;
          cam_din     <= wr_data;
        end
        WRITE:   state <= WR_WAIT;
        WR_WAIT: if (!cam_busy) begin
          state        <= ARB;
          lookup_first <= 1'b1;
        end
        default: state <= ARB;
      endcase
    end
endmodule

// File: tb/tb_cam_lookup_arbiter.sv
// tb_cam_lookup_arbiter: directed vectors and hand sequences for the CAM lookup arbiter
module tb_cam_lookup_arbiter;
  localparam int N = 4, KW = 32, AW = 5;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_vld = '0, req_ack, rsp_vld;
  logic [N*KW-1:0] req_key = '0;
  logic rsp_hit, wr_req = 1'b0, wr_ack, cam_cmp_req, cam_we, rsp_orphan;
  logic [AW-1:0] rsp_addr, wr_addr = '0, cam_wr_addr, cam_match_addr = '0;
  logic [KW-1:0] wr_data = '0, cam_cmp_din, cam_din;
  logic cam_busy = 1'b0, cam_rsp_vld = 1'b0, cam_match = 1'b0;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [N-1:0]  vld;
    logic          rv;
    logic          m;
    logic [AW-1:0] ma;
    logic [N-1:0]  e_ack;
    logic          e_cmp;
    logic [N-1:0]  e_rsp;
    logic          e_hit;
  } vec_t;
  vec_t tbl [13];
  logic [N-1:0] wd_exp [3];
  always #5 clk = ~clk;
  cam_lookup_arbiter #(.NUM_REQ(N), .KEY_WIDTH(KW), .ADDR_WIDTH(AW), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_key(req_key), .req_ack(req_ack),
    .rsp_vld(rsp_vld), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .cam_cmp_req(cam_cmp_req),
    .cam_cmp_din(cam_cmp_din), .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din),
    .cam_busy(cam_busy), .cam_rsp_vld(cam_rsp_vld), .cam_match(cam_match),
    .cam_match_addr(cam_match_addr), .rsp_orphan(rsp_orphan)
  );
  function automatic logic [KW-1:0] key_of(input int i);
    return 32'hC0A8_0100 + 32'(i);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < N; i++) req_key[i*KW +: KW] = key_of(i);
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0001, 1'b1, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0010, 1'b1, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0100, 1'b1, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b1000, 1'b1, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 1'b1, 5'd5, 4'b0000, 1'b0, 4'b0001, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 5'd0, 4'b0001, 1'b1, 4'b0010, 1'b0};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0010, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 1'b0, 5'd0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 5'd9, 4'b0000, 1'b0, 4'b0100, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 4'b1000, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 1'b0, 4'b0001, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 5'd2, 4'b0000, 1'b0, 4'b0010, 1'b1};
    wd_exp = '{4'b0100, 4'b0001, 4'b0010};
    step();
    step();
    chk("rst_req_ack", req_ack, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_cmp_req", cam_cmp_req, 0);
    chk("rst_cmp_din", cam_cmp_din, 0);
    chk("rst_cam_we", cam_we, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_orphan", rsp_orphan, 0);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req_vld = tbl[i].vld;
      cam_rsp_vld = tbl[i].rv;
      cam_match = tbl[i].m;
      cam_match_addr = tbl[i].ma;
      step();
      chk($sformatf("rr%0d_ack", i), req_ack, tbl[i].e_ack);
      chk($sformatf("rr%0d_cmp", i), cam_cmp_req, tbl[i].e_cmp);
      chk($sformatf("rr%0d_rsp", i), rsp_vld, tbl[i].e_rsp);
      chk($sformatf("rr%0d_hit", i), rsp_hit, tbl[i].e_hit);
    end
    req_vld = '0;
    cam_rsp_vld = 1'b0;
    cam_match = 1'b0;
    cam_match_addr = '0;
    req_vld = 4'b0100;
    step();
    chk("ord_ack2", req_ack, 4'b0100);
    chk("ord_key2", cam_cmp_din, key_of(2));
    req_vld = 4'b0001;
    step();
    chk("ord_ack0", req_ack, 4'b0001);
    chk("ord_key0", cam_cmp_din, key_of(0));
    req_vld = '0;
    cam_rsp_vld = 1'b1;
    cam_match = 1'b1;
    cam_match_addr = 5'd7;
    step();
    chk("ord_rsp2", rsp_vld, 4'b0100);
    chk("ord_hit2", rsp_hit, 1);
    chk("ord_addr2", rsp_addr, 7);
    cam_match = 1'b0;
    cam_match_addr = '0;
    step();
    chk("ord_rsp0", rsp_vld, 4'b0001);
    chk("ord_hit0", rsp_hit, 0);
    cam_rsp_vld = 1'b0;
    cam_busy = 1'b1;
    req_vld = 4'b0010;
    repeat (5) begin
      step();
      chk("bp_no_cmp", cam_cmp_req, 0);
    end
    cam_busy = 1'b0;
    step();
    chk("bp_ack", req_ack, 4'b0010);
    chk("bp_cmp", cam_cmp_req, 1);
    chk("bp_key", cam_cmp_din, key_of(1));
    req_vld = '0;
    cam_rsp_vld = 1'b1;
    step();
    chk("bp_rsp", rsp_vld, 4'b0010);
    cam_rsp_vld = 1'b0;
    req_vld = 4'b0111;
    step();
    chk("wd_ack_a", req_ack, 4'b0100);
    step();
    chk("wd_ack_b", req_ack, 4'b0001);
    step();
    chk("wd_ack_c", req_ack, 4'b0010);
    req_vld = 4'b1000;
    wr_req = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h0A00_0001;
    step();
    chk("wd_nogrant", req_ack, 0);
    chk("wd_we_early", cam_we, 0);
    cam_rsp_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wd_rsp%0d", i), rsp_vld, wd_exp[i]);
      chk($sformatf("wd_hold%0d", i), req_ack, 0);
      chk($sformatf("wd_we_hold%0d", i), cam_we, 0);
    end
    cam_rsp_vld = 1'b0;
    step();
    chk("wd_we", cam_we, 1);
    chk("wd_addr", cam_wr_addr, 3);
    chk("wd_din", cam_din, 32'h0A00_0001);
    chk("wd_we_ack", req_ack, 0);
    step();
    chk("wd_we_off", cam_we, 0);
    chk("wd_wr_ack", wr_ack, 1);
    wr_addr = 5'd4;
    wr_data = 32'h0B00_0002;
    step();
    chk("wd2_j_ack", req_ack, 0);
    chk("wd2_j_wr_ack", wr_ack, 0);
    cam_busy = 1'b1;
    step();
    chk("wd2_busy_ack", req_ack, 0);
    cam_busy = 1'b0;
    step();
    chk("wd2_first_ack", req_ack, 4'b1000);
    chk("wd2_first_key", cam_cmp_din, key_of(3));
    req_vld = '0;
    step();
    chk("wd2_drain_cmp", cam_cmp_req, 0);
    cam_rsp_vld = 1'b1;
    step();
    chk("wd2_rsp", rsp_vld, 4'b1000);
    chk("wd2_we_wait", cam_we, 0);
    cam_rsp_vld = 1'b0;
    step();
    chk("wd2_we", cam_we, 1);
    chk("wd2_addr", cam_wr_addr, 4);
    chk("wd2_din", cam_din, 32'h0B00_0002);
    step();
    chk("wd2_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    step();
    chk("wd2_wr_ack_off", wr_ack, 0);
    wr_req = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h55;
    step();
    chk("iw_we0", cam_we, 0);
    chk("iw_ack0", wr_ack, 0);
    step();
    chk("iw_we1", cam_we, 1);
    chk("iw_din", cam_din, 32'h55);
    step();
    chk("iw_ack", wr_ack, 1);
    chk("iw_we_off", cam_we, 0);
    wr_req = 1'b0;
    step();
    chk("no_orphan", rsp_orphan, 0);
    req_vld = 4'b0011;
    step();
    chk("rs_ack0", req_ack, 4'b0001);
    step();
    chk("rs_ack1", req_ack, 4'b0010);
    #2 reset = 1'b0;
    #1;
    chk("rs_async_ack", req_ack, 0);
    chk("rs_async_cmp", cam_cmp_req, 0);
    chk("rs_async_din", cam_cmp_din, 0);
    req_vld = '0;
    step();
    step();
    reset = 1'b1;
    cam_rsp_vld = 1'b1;
    step();
    chk("orph_rsp", rsp_vld, 0);
    chk("orph_flag", rsp_orphan, 1);
    cam_rsp_vld = 1'b0;
    step();
    chk("orph_sticky", rsp_orphan, 1);
    chk("orph_rsp_after", rsp_vld, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
